midi_event_framer: RTL and testbench

Frames the raw MIDI byte stream from the UART receiver into complete channel-voice events and buffers them in a small FIFO for the note/controller processor. Sits between the UART byte receiver and the voice-allocation logic, presenting each event as command plus two 7-bit parameters under a valid/ack handshake. Implements running status, drops system/real-time traffic, and optionally rewrites note-on with zero velocity as note-off.

---
 rtl/midi_event_framer_if.sv | 27 ++
 rtl/midi_event_framer.sv | 120 ++++++++++++
 tb/tb_midi_event_framer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/midi_event_framer_if.sv
// Byte-in / event-out bundle for the MIDI framer: raw UART bytes in, framed
// channel-voice events out under valid/ack, plus FIFO status.
interface midi_event_framer_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [7:0]                  rx_data;
  logic                        rx_valid;
  logic                        midi_event_valid;
  logic [7:0]                  midi_command;
  logic [6:0]                  midi_parameter_1;
  logic [6:0]                  midi_parameter_2;
  logic                        midi_event_ack;
  logic                        overflow;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  modport master (
    input  rx_data, rx_valid, midi_event_ack,
    output midi_event_valid, midi_command, midi_parameter_1, midi_parameter_2,
           overflow, fifo_level
  );

  modport slave (
    output rx_data, rx_valid, midi_event_ack,
    input  midi_event_valid, midi_command, midi_parameter_1, midi_parameter_2,
           overflow, fifo_level
  );
endinterface

// File: rtl/midi_event_framer.sv
// Frames MIDI bytes into channel-voice events (running status, sysex/real-time filtering) into a FIFO.
// Latency: event visible the cycle after its completing byte; no rx back-pressure, full FIFO drops and sets sticky overflow.
module midi_event_framer #(
  parameter int FIFO_DEPTH       = 4,
  parameter bit VEL0_IS_NOTE_OFF = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  midi_event_framer_if.master bus
);
  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0] cmd;
    logic [6:0] p1;
    logic [6:0] p2;
  } midi_evt_t;

  logic [7:0]    run_status;
  logic          run_vld;
  logic          need2;
  logic          got;
  logic          sysex;
  logic [6:0]    p1_q;

  logic          push;
  midi_evt_t     push_evt;
  midi_evt_t     mem [FIFO_DEPTH];
  midi_evt_t     head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   level;
  logic          ovf;
  logic          pop;
  logic          full;
  logic          do_push;

  // A data byte completes a message unless it is the first of a two-byte pair.
  always_comb begin
    push     = 1'b0;
    push_evt = '0;
    if (bus.rx_valid && !bus.rx_data[7] && !sysex && run_vld && (got || !need2)) begin
      push         = 1'b1;
      push_evt.cmd = run_status;
      push_evt.p1  = need2 ? p1_q : bus.rx_data[6:0];
      push_evt.p2  = need2 ? bus.rx_data[6:0] : 7'd0;
      if (VEL0_IS_NOTE_OFF && (run_status[7:4] == 4'h9) && (push_evt.p2 == 7'd0))
        push_evt.cmd = {4'h8, run_status[3:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_status <= '0;
      run_vld    <= 1'b0;
      need2      <= 1'b0;
      got        <= 1'b0;
      sysex      <= 1'b0;
      p1_q       <= '0;
    end else if (bus.rx_valid) begin
      if (!bus.rx_data[7]) begin
        if (!sysex && run_vld) begin
          if (!got && need2) begin
            p1_q <= bus.rx_data[6:0];
            got  <= 1'b1;
          end else begin
            got  <= 1'b0;
          end
        end
      end else if (bus.rx_data[7:4] != 4'hF) begin
        sysex      <= 1'b0;
        run_status <= bus.rx_data;
        run_vld    <= 1'b1;
        need2      <= (bus.rx_data[7:5] != 3'b110);
        got        <= 1'b0;
      end else if (!bus.rx_data[3]) begin
        // F0 opens sysex; F1-F7 (including the F7 terminator) close it.
        sysex   <= (bus.rx_data[2:0] == 3'd0);
        run_vld <= 1'b0;
        got     <= 1'b0;
      end
    end
  end

  assign pop     = bus.midi_event_ack && (level != '0);
  assign full    = (level == FULL_LVL);
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) ovf <= 1'b1;
      case ({do_push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_evt;
  end

  // Fields are forced to zero while empty so reset presents clean outputs.
  assign head                 = mem[rd_ptr];
  assign bus.midi_event_valid = (level != '0);
  assign bus.midi_command     = bus.midi_event_valid ? head.cmd : 8'd0;
  assign bus.midi_parameter_1 = bus.midi_event_valid ? head.p1 : 7'd0;
  assign bus.midi_parameter_2 = bus.midi_event_valid ? head.p2 : 7'd0;
  assign bus.overflow         = ovf;
  assign bus.fifo_level       = level;
endmodule

// File: tb/tb_midi_event_framer.sv
// Bench for midi_event_framer: byte-vector table plus hand sequences for
// overflow, wrap, full push/pop, reset and vel-0 variants, scoreboard-checked.
module tb_midi_event_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  midi_event_framer_if #(.FIFO_DEPTH(4)) bus0 ();
  midi_event_framer_if #(.FIFO_DEPTH(4)) bus1 ();

  midi_event_framer #(.FIFO_DEPTH(4), .VEL0_IS_NOTE_OFF(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  midi_event_framer #(.FIFO_DEPTH(4), .VEL0_IS_NOTE_OFF(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct packed {
    logic [0:7][7:0]  b;
    logic [3:0]       nb;
    logic [0:2][21:0] e;
    logic [1:0]       ne;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] sbq [$];
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic logic [21:0] ev(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    return {c, a[6:0], d[6:0]};
  endfunction

  function automatic logic [21:0] head0();
    return {bus0.midi_command, bus0.midi_parameter_1, bus0.midi_parameter_2};
  endfunction

  function automatic logic [21:0] head1();
    return {bus1.midi_command, bus1.midi_parameter_1, bus1.midi_parameter_2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic a);
    bus0.rx_data = b;
    bus0.rx_valid = 1'b1;
    bus1.rx_data = b;
    bus1.rx_valid = 1'b1;
    bus0.midi_event_ack = a;
    @(posedge clk);
    #1;
    bus0.rx_valid = 1'b0;
    bus1.rx_valid = 1'b0;
    bus0.midi_event_ack = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    bus0.midi_event_ack = 1'b1;
    @(posedge clk);
    #1;
    bus0.midi_event_ack = 1'b0;
  endtask

  // Pops every presented event with 1-cycle acks and 1-cycle gaps.
  task automatic drain(input string tag);
    int guard = 0;
    while (bus0.midi_event_valid && guard < 8) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_extra: got event %0h, expected none", tag, head0());
      end else begin
        chk({tag, "_evt"}, 32'(head0()), sbq.pop_front());
      end
      ack_pulse();
      idle();
      guard++;
    end
    chk({tag, "_empty"}, 32'(bus0.midi_event_valid), 32'd0);
    chk({tag, "_missing"}, sbq.size(), 32'd0);
    sbq.delete();
  endtask

  task automatic send_pair(input int k, input bit expect_push);
    send(8'(8'h30 + k), 1'b0);
    send(8'(k), 1'b0);
    if (expect_push) sbq.push_back(32'(ev(8'h90, 8'(8'h30 + k), 8'(k))));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.rx_data = '0; bus0.rx_valid = 1'b0; bus0.midi_event_ack = 1'b0;
    bus1.rx_data = '0; bus1.rx_valid = 1'b0; bus1.midi_event_ack = 1'b0;

    vecs[0] = '{b: {8'h90,8'h3C,8'h64,40'h0}, nb: 4'd3,
                e: {ev(8'h90,8'h3C,8'h64), 44'h0}, ne: 2'd1};
    vecs[1] = '{b: {8'h90,8'h3C,8'h64,8'h3E,8'h50,8'hC2,8'h05,8'h00}, nb: 4'd7,
                e: {ev(8'h90,8'h3C,8'h64), ev(8'h90,8'h3E,8'h50), ev(8'hC2,8'h05,8'h00)}, ne: 2'd3};
    vecs[2] = '{b: {8'h93,8'h40,8'h00,40'h0}, nb: 4'd3,
                e: {ev(8'h83,8'h40,8'h00), 44'h0}, ne: 2'd1};
    vecs[3] = '{b: {8'h90,8'hF8,8'h3C,8'hFE,8'h64,24'h0}, nb: 4'd5,
                e: {ev(8'h90,8'h3C,8'h64), 44'h0}, ne: 2'd1};
    vecs[4] = '{b: {8'hF0,8'h11,8'h22,8'hF7,8'h3C,8'h64,16'h0}, nb: 4'd6,
                e: 66'h0, ne: 2'd0};
    vecs[5] = '{b: {8'hB0,8'h01,8'hF0,8'h7F,8'hF7,24'h0}, nb: 4'd5,
                e: 66'h0, ne: 2'd0};
    vecs[6] = '{b: {8'hD5,8'h20,8'h21,40'h0}, nb: 4'd3,
                e: {ev(8'hD5,8'h20,8'h00), ev(8'hD5,8'h21,8'h00), 22'h0}, ne: 2'd2};
    vecs[7] = '{b: {8'h90,8'h3C,8'hE0,8'h10,8'h20,24'h0}, nb: 4'd5,
                e: {ev(8'hE0,8'h10,8'h20), 44'h0}, ne: 2'd1};

    do_reset();
    chk("rst_valid", 32'(bus0.midi_event_valid), 32'd0);
    chk("rst_overflow", 32'(bus0.overflow), 32'd0);
    chk("rst_level", 32'(bus0.fifo_level), 32'd0);
    chk("rst_fields", 32'(head0()), 32'd0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int i = 0; i < 3; i++)
        if (i < int'(vecs[v].ne)) sbq.push_back(32'(vecs[v].e[i]));
      for (int i = 0; i < int'(vecs[v].nb); i++) begin
        if (i == int'(vecs[v].nb) - 1 && vecs[v].ne == 2'd1)
          chk($sformatf("v%0d_lat_pre", v), 32'(bus0.midi_event_valid), 32'd0);
        send(vecs[v].b[i], 1'b0);
      end
      chk($sformatf("v%0d_valid", v), 32'(bus0.midi_event_valid), 32'(vecs[v].ne != 2'd0));
      chk($sformatf("v%0d_level", v), 32'(bus0.fifo_level), 32'(vecs[v].ne));
      drain($sformatf("v%0d", v));
    end

    // Vel-0 passthrough when the rewrite is disabled.
    do_reset();
    send(8'h93, 1'b0); send(8'h40, 1'b0); send(8'h00, 1'b0);
    chk("nv_valid", 32'(bus1.midi_event_valid), 32'd1);
    chk("nv_evt", 32'(head1()), 32'(ev(8'h93, 8'h40, 8'h00)));
    chk("nv_level", 32'(bus1.fifo_level), 32'd1);
    sbq.push_back(32'(ev(8'h83, 8'h40, 8'h00)));
    drain("vel0_on");

    // Overflow, then wrap.
    do_reset();
    send(8'h90, 1'b0);
    for (int k = 1; k <= 5; k++) send_pair(k, k <= 4);
    chk("ovf_level", 32'(bus0.fifo_level), 32'd4);
    chk("ovf_flag", 32'(bus0.overflow), 32'd1);
    drain("ovf");
    chk("ovf_sticky", 32'(bus0.overflow), 32'd1);
    for (int r = 0; r < 2; r++) begin
      for (int k = 6; k <= 8; k++) send_pair(k + 3 * r, 1'b1);
      chk($sformatf("wrap%0d_level", r), 32'(bus0.fifo_level), 32'd3);
      drain($sformatf("wrap%0d", r));
    end

    // Full FIFO, push and pop in the same cycle.
    do_reset();
    send(8'h90, 1'b0);
    for (int k = 1; k <= 4; k++) send_pair(k, 1'b1);
    send(8'h35, 1'b0);
    chk("fullpp_head", 32'(head0()), sbq.pop_front());
    sbq.push_back(32'(ev(8'h90, 8'h35, 8'h05)));
    send(8'h05, 1'b1);
    chk("fullpp_level", 32'(bus0.fifo_level), 32'd4);
    chk("fullpp_overflow", 32'(bus0.overflow), 32'd0);
    drain("fullpp");

    // Level 1, push and pop in the same cycle.
    do_reset();
    send(8'h90, 1'b0); send(8'h41, 1'b0); send(8'h11, 1'b0);
    send(8'h42, 1'b0);
    chk("l1pp_head", 32'(head0()), 32'(ev(8'h90, 8'h41, 8'h11)));
    send(8'h12, 1'b1);
    chk("l1pp_valid", 32'(bus0.midi_event_valid), 32'd1);
    chk("l1pp_level", 32'(bus0.fifo_level), 32'd1);
    sbq.push_back(32'(ev(8'h90, 8'h42, 8'h12)));
    drain("l1pp");

    // Reset with FIFO contents and mid-message.
    do_reset();
    send(8'h90, 1'b0); send(8'h3C, 1'b0); send(8'h64, 1'b0); send(8'h90, 1'b0);
    do_reset();
    chk("rstmid_level", 32'(bus0.fifo_level), 32'd0);
    chk("rstmid_fields", 32'(head0()), 32'd0);
    send(8'h3C, 1'b0); send(8'h64, 1'b0);
    chk("rstmid_valid_after", 32'(bus0.midi_event_valid), 32'd0);
    chk("rstmid_level_after", 32'(bus0.fifo_level), 32'd0);

    // Ack while empty must not disturb the level.
    do_reset();
    ack_pulse();
    chk("emptyack_level", 32'(bus0.fifo_level), 32'd0);
    send(8'h90, 1'b0); send(8'h3C, 1'b0); send(8'h64, 1'b0);
    chk("emptyack_level_after", 32'(bus0.fifo_level), 32'd1);
    sbq.push_back(32'(ev(8'h90, 8'h3C, 8'h64)));
    drain("emptyack");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
